ch_best_finder: RTL and testbench
=================================

# ch_best_finder

Scanner that sits directly downstream of the cluster-head memory bank. On `start`, it walks the bank's 16-bit entries one per cycle through the bank's combinational read port and reports the entry with the largest value (the best cluster-head score) and its byte index. It is used by the node's RL routing logic to pick the next-hop cluster head, and it never writes the bank.

## Interface
Parameters:
- `WORD_WIDTH`, 16, entry width in bits; also the width of the bank index bus.
- `MAX_ENTRIES`, 16, capacity of the bank in words (32 bytes / 2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `count`  in  5  number of entries to scan (0..16); sampled with `start`.
- `mem_index`  out  WORD_WIDTH  byte index driven to the bank's `index`; always even.
- `mem_data`  in  WORD_WIDTH  bank `data_out`, valid in the same cycle as `mem_index`.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse when results are final.
- `found`  out  1  result valid, meaning at least one entry was scanned.
- `best_value`  out  WORD_WIDTH  largest entry value seen.
- `best_index`  out  WORD_WIDTH  byte index of `best_value`.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - On `start`=1, latch `n = min(count, MAX_ENTRIES)`.
  - Clear `found`, `best_value` and `best_index` to 0.
  - Go to SCAN if `n > 0`, otherwise go to DONE.
- SCAN:
  - The entry counter `k` runs 0..n-1 and `mem_index = 2*k`.
  - Each cycle, compare `mem_data` as unsigned against `best_value`.
  - Take the new entry when `found`=0 or `mem_data > best_value`; this also sets `found`=1.
  - Ties keep the earlier (lower) index.
  - After entry n-1, go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` is ignored while `busy`=1. No queuing.
- Results (`found`, `best_value`, `best_index`) hold from DONE until the next accepted `start`.
- `mem_index` is 0 whenever the block is not in SCAN.
- Counter arithmetic:
  - `k` is 5 bits, so there is no wrap at 16.
  - `mem_index` is `{k, 1'b0}`, zero-extended to WORD_WIDTH.
  - Index n-1 is at most 15, so the highest read is byte 30, and the bank's `index+1` stays at or below 31.
- `count` > 16 is clamped to 16.
- `count` = 0 completes with `found`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `best_value`=0, `best_index`=0, `mem_index`=0.
- `start` accepted at edge t:
  - SCAN runs in cycles t+1 .. t+n, with entry k read in cycle t+1+k.
  - DONE is in cycle t+n+1 (`done`=1); IDLE resumes at t+n+2.
  - Latency from `start` to `done` is n+1 cycles; with n=0 it is 1 cycle.
- The compare and update use `mem_data` in the same cycle as `mem_index`, with no read latency. Results for entry k are registered at the end of cycle t+1+k.
- Earliest next `start` is accepted in the first IDLE cycle (t+n+2).
- A bank write in the same cycle as a read of that word is not coordinated here. The surrounding control keeps the bank's `wr_en` low while `busy`=1.
- `rst` mid-scan: the next cycle is IDLE with all outputs at their reset values and no `done` pulse.

## Structure
- Shared package `eer_rl_pkg`:
  - `WORD_WIDTH`, `MEM_DEPTH` (=32) and `MAX_ENTRIES` constants.
  - The `ch_state_t` enum {IDLE, SCAN, DONE}.
- No sub-module. The compare and update is a single inline unsigned comparator.
- The memory bank is instantiated beside this block, not inside it.

## Test plan
- Bank words 0..3 = 0x0010, 0x0500, 0x0020, 0x0400; `count`=4 -> `done` 5 cycles after `start`; `best_value`=0x0500, `best_index`=2, `found`=1.
- Tie: words = 0x0300, 0x0700, 0x0700; `count`=3 -> `best_index`=2 (first max), `best_value`=0x0700.
- `count`=0 -> `done` the cycle after `start`; `found`=0, `best_value`=0, `mem_index` stays 0.
- `count`=20 with word 15 = 0xFFFF, others = 1 -> scan stops at `mem_index`=30 (16 reads); `best_index`=30, `best_value`=0xFFFF.
- Second `start` during a 4-entry scan -> ignored, exactly one `done`; then `rst` during a fresh scan at k=2 -> next cycle `busy`=0, all outputs 0, no `done`.
- All words 0x0000, `count`=5 -> `found`=1, `best_value`=0, `best_index`=0.

Source files
------------

// File: rtl/eer_rl_pkg.sv
// Shared constants and types for the RL routing datapath blocks.
package eer_rl_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int MEM_DEPTH   = 32;              // bank size in bytes
    localparam int MAX_ENTRIES = MEM_DEPTH / 2;   // bank size in 16-bit words

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } ch_state_t;

endpackage : eer_rl_pkg

// File: rtl/ch_best_finder_if.sv
// Request/result and bank read-port signals of the cluster-head best finder.
// master: the surrounding control plus the bank's read data; slave: the finder.
interface ch_best_finder_if #(
    parameter int WORD_WIDTH = eer_rl_pkg::WORD_WIDTH
);
    logic                  start;
    logic [4:0]            count;
    logic [WORD_WIDTH-1:0] mem_index;
    logic [WORD_WIDTH-1:0] mem_data;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [WORD_WIDTH-1:0] best_value;
    logic [WORD_WIDTH-1:0] best_index;

    modport master (
        output start, count, mem_data,
        input  mem_index, busy, done, found, best_value, best_index
    );

    modport slave (
        input  start, count, mem_data,
        output mem_index, busy, done, found, best_value, best_index
    );
endinterface : ch_best_finder_if

// File: rtl/ch_best_finder.sv
// Walks the cluster-head bank one word per cycle through its combinational
// read port and reports the largest (unsigned) entry and its byte index.
// The bank is read-only from here; ties keep the lowest index.
module ch_best_finder #(
    parameter int WORD_WIDTH  = eer_rl_pkg::WORD_WIDTH,
    parameter int MAX_ENTRIES = eer_rl_pkg::MAX_ENTRIES
) (
    input logic             clk,
    input logic             rst,
    ch_best_finder_if.slave bus
);

    localparam logic [4:0] N_MAX = 5'(MAX_ENTRIES);

    eer_rl_pkg::ch_state_t state_q, state_d;

    logic [4:0]            n_q;       // entries to scan in this request
    logic [4:0]            k_q;       // entry being read; 5 bits so 16 never wraps
    logic                  found_q;
    logic [WORD_WIDTH-1:0] best_value_q;
    logic [WORD_WIDTH-1:0] best_index_q;

    logic [4:0]            n_start;
    logic                  last_entry;
    logic                  take;
    logic [WORD_WIDTH-1:0] cur_index;

    assign n_start    = (bus.count > N_MAX) ? N_MAX : bus.count;
    assign last_entry = (k_q == n_q - 5'd1);
    assign cur_index  = WORD_WIDTH'({k_q, 1'b0});
    // Strict greater-than: an equal later entry never displaces the first max.
    assign take       = !found_q || (bus.mem_data > best_value_q);

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            eer_rl_pkg::IDLE: begin
                if (bus.start) begin
                    state_d = (n_start != 5'd0) ? eer_rl_pkg::SCAN : eer_rl_pkg::DONE;
                end
            end
            eer_rl_pkg::SCAN: begin
                if (last_entry) begin
                    state_d = eer_rl_pkg::DONE;
                end
            end
            eer_rl_pkg::DONE: state_d = eer_rl_pkg::IDLE;
            default:          state_d = eer_rl_pkg::IDLE;
        endcase
    end

    // State register, scan counter and running best-so-far.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= eer_rl_pkg::IDLE;
            n_q          <= '0;
            k_q          <= '0;
            found_q      <= 1'b0;
            best_value_q <= '0;
            best_index_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                eer_rl_pkg::IDLE: begin
                    if (bus.start) begin
                        n_q          <= n_start;
                        k_q          <= '0;
                        found_q      <= 1'b0;
                        best_value_q <= '0;
                        best_index_q <= '0;
                    end
                end
                eer_rl_pkg::SCAN: begin
                    if (take) begin
                        found_q      <= 1'b1;
                        best_value_q <= bus.mem_data;
                        best_index_q <= cur_index;
                    end
                    k_q <= k_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: bank index is parked at 0 outside SCAN; results hold until the next start.
    assign bus.mem_index  = (state_q == eer_rl_pkg::SCAN) ? cur_index : '0;
    assign bus.busy       = (state_q != eer_rl_pkg::IDLE);
    assign bus.done       = (state_q == eer_rl_pkg::DONE);
    assign bus.found      = found_q;
    assign bus.best_value = best_value_q;
    assign bus.best_index = best_index_q;

endmodule : ch_best_finder

// File: tb/tb_ch_best_finder.sv
// Self-checking bench for ch_best_finder: a word-array bank model drives the
// read port, expected results are queued at start and popped at done.
module tb_ch_best_finder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ch_best_finder_if #(.WORD_WIDTH(16)) bus ();

    ch_best_finder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank model: word array addressed by byte index / 2, combinational read.
    logic [15:0] bank [16];
    assign bus.mem_data = bank[bus.mem_index[4:1]];

    typedef struct {
        logic        found;
        logic [15:0] value;
        logic [15:0] index;
        int          latency;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] cnt);
        exp_t e;
        int   n;
        n = (cnt > 5'd16) ? 16 : int'(cnt);
        e.found = 1'b0;
        e.value = '0;
        e.index = '0;
        e.latency = n + 1;
        for (int i = 0; i < n; i++) begin
            if (!e.found || bank[i] > e.value) begin
                e.found = 1'b1;
                e.value = bank[i];
                e.index = 16'(2 * i);
            end
        end
        return e;
    endfunction

    // Issue one scan; optionally pulse a second start mid-scan. Called at posedge+1.
    task automatic run_scan(input string name, input logic [4:0] cnt, input bit inject_start);
        exp_t e;
        int   cyc;
        int   max_idx;
        int   extra_done;
        sb.push_back(model(cnt));
        bus.start = 1'b1;
        bus.count = cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        max_idx = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            check({name, "_busy_scan"}, 32'(bus.busy), 32'd1);
            check({name, "_mem_index"}, 32'(bus.mem_index), 32'(2 * (cyc - 1)));
            if (int'(bus.mem_index) > max_idx) max_idx = int'(bus.mem_index);
            if (inject_start) bus.start = (cyc == 2);
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        e = sb.pop_front();
        check({name, "_latency"},    32'(cyc),             32'(e.latency));
        check({name, "_found"},      32'(bus.found),       32'(e.found));
        check({name, "_best_value"}, 32'(bus.best_value),  32'(e.value));
        check({name, "_best_index"}, 32'(bus.best_index),  32'(e.index));
        check({name, "_busy_done"},  32'(bus.busy),        32'd1);
        check({name, "_mem_index_done"}, 32'(bus.mem_index), 32'd0);
        if (cnt == 5'd20) check({name, "_max_read"}, 32'(max_idx), 32'd30);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_busy_idle"},  32'(bus.busy), 32'd0);
        check({name, "_hold_value"}, 32'(bus.best_value), 32'(e.value));
        check({name, "_hold_index"}, 32'(bus.best_index), 32'(e.index));
        check({name, "_hold_found"}, 32'(bus.found), 32'(e.found));
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra_done++;
        end
        check({name, "_extra_done"}, 32'(extra_done), 32'd0);
    endtask

    initial begin
        int extra_done;
        bus.start = 1'b0;
        bus.count = '0;
        for (int i = 0; i < 16; i++) bank[i] = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_found",      32'(bus.found),      32'd0);
        check("rst_best_value", 32'(bus.best_value), 32'd0);
        check("rst_best_index", 32'(bus.best_index), 32'd0);
        check("rst_mem_index",  32'(bus.mem_index),  32'd0);
        @(posedge clk); #1;

        // Basic: max in word 1
        bank[0] = 16'h0010; bank[1] = 16'h0500; bank[2] = 16'h0020; bank[3] = 16'h0400;
        run_scan("basic", 5'd4, 1'b0);

        // Tie keeps the first maximum
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
        bank[0] = 16'h0300; bank[1] = 16'h0700; bank[2] = 16'h0700;
        run_scan("tie", 5'd3, 1'b0);

        // count = 0
        run_scan("empty", 5'd0, 1'b0);

        // count clamped to 16, max in the last word
        for (int i = 0; i < 16; i++) bank[i] = 16'h0001;
        bank[15] = 16'hFFFF;
        run_scan("clamp", 5'd20, 1'b0);

        // Max in the first word, count exactly 16
        for (int i = 0; i < 16; i++) bank[i] = 16'(i);
        bank[0] = 16'h8000;
        run_scan("first", 5'd16, 1'b0);

        // Second start during a scan is ignored
        bank[0] = 16'h0010; bank[1] = 16'h0500; bank[2] = 16'h0020; bank[3] = 16'h0400;
        run_scan("restart", 5'd4, 1'b1);

        // Reset at k=2 during a fresh scan
        bank[0] = 16'h0900; bank[1] = 16'h0100;
        bus.start = 1'b1;
        bus.count = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_k2_index", 32'(bus.mem_index), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy",       32'(bus.busy),       32'd0);
        check("midrst_done",       32'(bus.done),       32'd0);
        check("midrst_found",      32'(bus.found),      32'd0);
        check("midrst_best_value", 32'(bus.best_value), 32'd0);
        check("midrst_best_index", 32'(bus.best_index), 32'd0);
        check("midrst_mem_index",  32'(bus.mem_index),  32'd0);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra_done++;
        end
        check("midrst_no_done", 32'(extra_done), 32'd0);

        // All zeros: found still set, index 0
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
        run_scan("zeros", 5'd5, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ch_best_finder
